// File: rtl/alu_arbiter_if.sv
// Bundle between the requesting units, the shared ALU and alu_arbiter.
// The arbiter connects through the slave modport. The requesters and the ALU
// together use the master modport.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NREQ       = 2
);
    localparam int IDW = $clog2(NREQ);

    // requester side
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ*DATA_WIDTH-1:0] req_in1;
    logic [NREQ*DATA_WIDTH-1:0] req_in2;
    logic [NREQ*3-1:0]          req_ctrl;

    // response side
    logic [NREQ-1:0]            resp_valid;
    logic [NREQ-1:0]            resp_ready;
    logic [DATA_WIDTH-1:0]      resp_out;
    logic                       resp_eq;
    logic                       resp_err;
    logic [IDW-1:0]             resp_id;

    // shared ALU
    logic [DATA_WIDTH-1:0]      alu_in1;
    logic [DATA_WIDTH-1:0]      alu_in2;
    logic [2:0]                 alu_ctrl;
    logic [DATA_WIDTH-1:0]      alu_out;
    logic                       alu_eq;

    modport slave (
        input  req_valid, req_in1, req_in2, req_ctrl, resp_ready, alu_out, alu_eq,
        output req_ready, resp_valid, resp_out, resp_eq, resp_err, resp_id,
               alu_in1, alu_in2, alu_ctrl
    );

    modport master (
        output req_valid, req_in1, req_in2, req_ctrl, resp_ready, alu_out, alu_eq,
        input  req_ready, resp_valid, resp_out, resp_eq, resp_err, resp_id,
               alu_in1, alu_in2, alu_ctrl
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NREQ requesters.
// One operation is in flight at a time: IDLE (accept) -> EXEC (drive ALU) -> RESP.
// Illegal op codes never reach the ALU. The response for such an op is forced to
// result 0 with eq and err set.
module alu_arbiter #(
    parameter int  DATA_WIDTH = 32,
    parameter int  NREQ       = 2,
    localparam int IDW        = $clog2(NREQ)
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    localparam int CW = IDW + 1;

    generate
        if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
            $error("alu_arbiter: NREQ must be in 2..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [IDW-1:0]         rr_ptr, rr_ptr_nx;

    logic                   grant_vld;
    logic [IDW-1:0]         grant_id;
    logic [CW-1:0]          cand;
    logic                   accept;

    // operands latched at accept
    logic [DATA_WIDTH-1:0]  in1_p0;
    logic [DATA_WIDTH-1:0]  in2_p0;
    logic [2:0]             ctrl_p0;
    logic [IDW-1:0]         id_p0;
    logic                   err_p0;

    // result captured at the end of EXEC
    logic [DATA_WIDTH-1:0]  out_p1;
    logic                   eq_p1;

    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        resp_valid;
    logic [DATA_WIDTH-1:0]  resp_out;
    logic                   resp_eq;
    logic                   resp_err;
    logic [IDW-1:0]         resp_id;
    logic [DATA_WIDTH-1:0]  alu_in1;
    logic [DATA_WIDTH-1:0]  alu_in2;
    logic [2:0]             alu_ctrl;

    // Codes 100, 110 and 111 have no ALU operation behind them.
    function automatic logic op_illegal(input logic [2:0] code);
        return (code == 3'b100) || (code == 3'b110) || (code == 3'b111);
    endfunction

    // Round-robin search: first valid requester starting at rr_ptr, wrapping mod NREQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!grant_vld && bus.req_valid[cand[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = cand[IDW-1:0];
            end
        end
    end

    // A request is accepted only from IDLE, and never while reset is held.
    assign accept = (state == IDLE) && grant_vld && !rst;

    // Control state: FSM and round-robin pointer, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
        end else begin
            state  <= state_nx;
            rr_ptr <= rr_ptr_nx;
        end
    end

    // Next state and all handshake/ALU outputs; everything defaults to zero.
    always_comb begin
        state_nx   = state;
        rr_ptr_nx  = rr_ptr;
        req_ready  = '0;
        resp_valid = '0;
        resp_out   = '0;
        resp_eq    = 1'b0;
        resp_err   = 1'b0;
        resp_id    = '0;
        alu_in1    = '0;
        alu_in2    = '0;
        alu_ctrl   = 3'b000;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready[grant_id] = 1'b1;
                    state_nx            = EXEC;
                end
            end
            EXEC: begin
                alu_in1  = in1_p0;
                alu_in2  = in2_p0;
                alu_ctrl = err_p0 ? 3'b000 : ctrl_p0;
                state_nx = RESP;
            end
            RESP: begin
                resp_valid[id_p0] = 1'b1;
                resp_out          = out_p1;
                resp_eq           = eq_p1;
                resp_err          = err_p0;
                resp_id           = id_p0;
                // only the owner's resp_ready completes the handshake
                if (bus.resp_ready[id_p0]) begin
                    state_nx  = IDLE;
                    rr_ptr_nx = (id_p0 == IDW'(NREQ - 1)) ? '0 : id_p0 + IDW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand latch on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            in1_p0  <= bus.req_in1[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
            in2_p0  <= bus.req_in2[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
            ctrl_p0 <= bus.req_ctrl[int'(grant_id)*3 +: 3];
            id_p0   <= grant_id;
            err_p0  <= op_illegal(bus.req_ctrl[int'(grant_id)*3 +: 3]);
        end
    end

    // Result capture at the end of EXEC; illegal ops override the ALU with 0 / eq.
    always_ff @(posedge clk) begin
        if (state == EXEC) begin
            out_p1 <= err_p0 ? '0 : bus.alu_out;
            eq_p1  <= err_p0 | bus.alu_eq;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_out   = resp_out;
    assign bus.resp_eq    = resp_eq;
    assign bus.resp_err   = resp_err;
    assign bus.resp_id    = resp_id;
    assign bus.alu_in1    = alu_in1;
    assign bus.alu_in2    = alu_in2;
    assign bus.alu_ctrl   = alu_ctrl;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters and a behavioural ALU.
module tb_alu_arbiter;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    alu_arbiter_if #(.DATA_WIDTH(32), .NREQ(2)) bus ();

    alu_arbiter #(.DATA_WIDTH(32), .NREQ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // behavioural ALU
    logic [31:0] alu_r;
    always_comb begin
        alu_r = 32'd0;
        case (bus.alu_ctrl)
            3'b000:  alu_r = bus.alu_in1 + bus.alu_in2;
            3'b001:  alu_r = bus.alu_in1 - bus.alu_in2;
            3'b010:  alu_r = bus.alu_in1 & bus.alu_in2;
            3'b011:  alu_r = bus.alu_in1 | bus.alu_in2;
            3'b101:  alu_r = ($signed(bus.alu_in1) < $signed(bus.alu_in2)) ? 32'd1 : 32'd0;
            default: alu_r = 32'd0;
        endcase
        bus.alu_out = alu_r;
        bus.alu_eq  = (alu_r == 32'd0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // move to just after the next falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] c);
        bus.req_in1[i*32 +: 32] = a;
        bus.req_in2[i*32 +: 32] = b;
        bus.req_ctrl[i*3 +: 3]  = c;
        bus.req_valid[i]        = 1'b1;
    endtask

    task automatic clr_req(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, input logic [2:0] xctrl,
                         input logic [31:0] xout, input logic xeq, input logic xerr,
                         input string tag);
        logic [1:0] oh;
        oh    = 2'b00;
        oh[i] = 1'b1;
        set_req(i, a, b, c);
        #1;
        chk({tag, ".req_ready"}, bus.req_ready, oh);
        step();
        clr_req(i);
        #1;
        chk({tag, ".alu_ctrl"}, bus.alu_ctrl, xctrl);
        chk({tag, ".alu_in1"}, bus.alu_in1, a);
        step();
        chk({tag, ".resp_valid"}, bus.resp_valid, oh);
        chk({tag, ".resp_out"}, bus.resp_out, xout);
        chk({tag, ".resp_eq"}, bus.resp_eq, xeq);
        chk({tag, ".resp_err"}, bus.resp_err, xerr);
        chk({tag, ".resp_id"}, bus.resp_id, i[0]);
        step();
        chk({tag, ".done"}, bus.resp_valid, 2'b00);
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_in1    = '0;
        bus.req_in2    = '0;
        bus.req_ctrl   = '0;
        bus.resp_ready = 2'b11;

        // reset state, including a request presented while reset is held
        #2;
        set_req(0, 32'd7, 32'd5, 3'b000);
        #1;
        chk("rst.req_ready", bus.req_ready, 2'b00);
        chk("rst.resp_valid", bus.resp_valid, 2'b00);
        chk("rst.resp_bus", {bus.resp_out, bus.resp_eq, bus.resp_err, bus.resp_id}, '0);
        chk("rst.alu_bus", {bus.alu_in1, bus.alu_in2, bus.alu_ctrl}, '0);
        clr_req(0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // single op: r0 add 7+5
        set_req(0, 32'd7, 32'd5, 3'b000);
        #1;
        chk("t1.req_ready", bus.req_ready, 2'b01);
        step();
        clr_req(0);
        #1;
        chk("t1.exec_alu", {bus.alu_in1, bus.alu_in2, bus.alu_ctrl}, {32'd7, 32'd5, 3'b000});
        chk("t1.exec_ready", bus.req_ready, 2'b00);
        chk("t1.exec_valid", bus.resp_valid, 2'b00);
        step();
        chk("t1.resp_valid", bus.resp_valid, 2'b01);
        chk("t1.resp_out", bus.resp_out, 32'd12);
        chk("t1.resp_flags", {bus.resp_eq, bus.resp_err, bus.resp_id}, 3'b000);
        step();
        chk("t1.done", bus.resp_valid, 2'b00);
        chk("t1.alu_idle", {bus.alu_in1, bus.alu_ctrl}, '0);

        // contention from a fresh reset, then back-pressure on r1
        rst = 1'b1;
        #1;
        rst = 1'b0;
        set_req(0, 32'd1, 32'd2, 3'b000);
        set_req(1, 32'd10, 32'd3, 3'b001);
        #1;
        chk("t2.first_grant", bus.req_ready, 2'b01);
        step();
        set_req(0, 32'h0000_00F0, 32'h0000_003C, 3'b010);
        bus.resp_ready = 2'b01;
        #1;
        chk("t2.exec_no_ready", bus.req_ready, 2'b00);
        step();
        chk("t2.r0_valid", bus.resp_valid, 2'b01);
        chk("t2.r0_out", bus.resp_out, 32'd3);
        step();
        chk("t2.second_grant", bus.req_ready, 2'b10);
        step();
        clr_req(1);
        step();
        for (int c = 0; c < 5; c++) begin
            chk("t3.hold_valid", bus.resp_valid, 2'b10);
            chk("t3.hold_out", {bus.resp_out, bus.resp_eq, bus.resp_err, bus.resp_id},
                {32'd7, 1'b0, 1'b0, 1'b1});
            chk("t3.no_accept", bus.req_ready, 2'b00);
            step();
        end
        chk("t3.still_valid", bus.resp_valid, 2'b10);
        bus.resp_ready = 2'b11;
        step();
        chk("t2.r0_regrant", bus.req_ready, 2'b01);
        step();
        clr_req(0);
        step();
        chk("t2.r0_and_valid", bus.resp_valid, 2'b01);
        chk("t2.r0_and_out", bus.resp_out, 32'h0000_0030);
        chk("t2.r0_and_id", bus.resp_id, 1'b0);
        step();

        // slt, sub to zero, illegal op
        do_op(0, 32'hFFFF_FFFF, 32'd1, 3'b101, 3'b101, 32'd1, 1'b0, 1'b0, "t4.slt");
        do_op(1, 32'd9, 32'd9, 3'b001, 3'b001, 32'd0, 1'b1, 1'b0, "t4.sub");
        do_op(0, 32'd3, 32'd4, 3'b110, 3'b000, 32'd0, 1'b1, 1'b1, "t5.illegal");

        // reset while an r1 op is in EXEC (rr_ptr is 1 beforehand)
        set_req(1, 32'd1, 32'd1, 3'b000);
        #1;
        chk("t6.grant_r1", bus.req_ready, 2'b10);
        step();
        clr_req(1);
        #1;
        chk("t6.exec_in1", bus.alu_in1, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6.rst_alu", {bus.alu_in1, bus.alu_in2, bus.alu_ctrl}, '0);
        chk("t6.rst_hs", {bus.req_ready, bus.resp_valid}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("t6.no_resp", bus.resp_valid, 2'b00);
            step();
        end
        set_req(0, 32'd2, 32'd2, 3'b000);
        set_req(1, 32'd5, 32'd5, 3'b000);
        #1;
        chk("t6.grant_from_0", bus.req_ready, 2'b01);
        step();
        clr_req(0);
        step();
        chk("t6.r0_out", {bus.resp_valid, bus.resp_out}, {2'b01, 32'd4});
        clr_req(1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
